tdm_demux4: RTL and testbench
=============================

# tdm_demux4

Time-division 1-to-4 demultiplexer: the receiving end of the team's 4-to-1 select path. It accepts one data word per valid cycle on a single shared line and routes it to one of four registered channel outputs, either by an internal round-robin slot counter (frame mode) or by an explicit select (direct mode). In frame mode it reassembles complete 4-slot frames and flags frame completion and alignment errors. It sits between a multiplexed source (switch-driven or serialised) and per-channel consumers such as LED/HEX display logic.

## Interface
- WIDTH, 1, data width of each channel word

- clk  in  1  system clock, all state updates on rising edge
- resetn  in  1  reset; one clock; reset is asynchronous and active-low
- din  in  WIDTH  shared input data word
- din_valid  in  1  din is valid this cycle; nothing changes when low
- sync  in  1  qualifies din as slot 0 of a new frame (frame mode only)
- mode  in  1  0 = frame (round-robin) mode, 1 = direct-select mode
- sel  in  2  target channel in direct mode; ignored in frame mode
- ch0, ch1, ch2, ch3  out  WIDTH  registered channel outputs; each holds its last written word
- ch_upd  out  4  one-hot, bit i high for one cycle when ch_i was written
- slot  out  2  next round-robin slot to be written
- frame_valid  out  1  one-cycle pulse: a complete frame was captured
- frame  out  4*WIDTH  {ch3,ch2,ch1,ch0} snapshot of last complete frame; holds until next frame_valid
- sync_err  out  1  one-cycle pulse: sync arrived mid-frame, partial frame discarded

## Operation
- Internal state: slot[1:0], fill[3:0] (slots written in current frame), channel registers, frame register.
- Target selection on a cycle with din_valid=1:
  - mode=1: target = sel; write ch[target]; slot and fill forced to 0; sync ignored; no frame_valid, no sync_err.
  - mode=0, sync=1: target = 0; if fill != 0, pulse sync_err (partial frame dropped; already written ch registers keep values); fill <= 4'b0001; slot <= 1.
  - mode=0, sync=0: target = slot; fill[target] <= 1; slot <= slot+1, wrapping 3 -> 0.
- Frame completion (mode=0): when target = 3 and fill[2:0] = 3'b111 (including this cycle's writes), load frame with {din, ch2, ch1, ch0}, pulse frame_valid; fill cleared to 0 as slot wraps to 0.
- Target = 3 with fill[2:0] incomplete (e.g. after power-up or a mode switch landing mid-frame): ch3 written, no frame_valid, fill cleared, slot wraps to 0.
- din_valid=0: all registers hold; ch_upd, frame_valid, sync_err are 0. mode=1 with din_valid=0 still clears slot and fill.
- Switching mode 1 -> 0 therefore always starts at slot 0 with empty fill.
- Reset (asserted at any time, including mid-frame): ch0..ch3, frame, slot, fill, ch_upd, frame_valid, sync_err all 0 immediately; partial frame lost.

## Timing
- All outputs registered; 1-cycle latency: word sampled at edge N appears on ch_target, with ch_upd bit, after edge N.
- frame_valid, frame and the ch3 update are visible in the same cycle.
- sync_err is visible in the same cycle as the ch0 write of the new frame.
- Full throughput: one word per clock, back-to-back frames with no idle cycle; frame_valid may pulse every 4th cycle.
- sync asserted exactly on a wrap (fill = 0, slot = 0) is legal: no sync_err.
- Reset deassertion: first valid word may be sampled on the first rising edge after resetn goes high.

## Test plan
- Reset: drive values, assert resetn=0 mid-frame -> all outputs 0 without a clock edge; slot=0 after release.
- Frame mode, WIDTH=4, sync on first word, din=A,B,C,D on 4 consecutive valid cycles -> ch0..ch3 = A,B,C,D, ch_upd walks 0001,0010,0100,1000, frame_valid one cycle with frame=16'hDCBA, slot=0.
- Gapped input: same four words with din_valid low 2 cycles between each -> same result; outputs hold during gaps; single frame_valid.
- Mid-frame sync: words 1,2 (sync on 1), then sync with word 7 -> sync_err one cycle, ch0=7, slot=1, no frame_valid until 3 more words complete frame.
- Direct mode: mode=1, sel=2, din=5 -> ch2=5, ch_upd=0100, slot=0, no frame_valid; then mode=0 with words 1..4 -> frame=16'h4321.
- Unaligned start: after reset, no sync, 4 words 9,8,7,6 -> frame_valid fires (fill complete from slot 0); after mode toggle mid-frame, next write to ch3 alone -> no frame_valid.

Source files
------------

// File: rtl/tdm_demux4.sv
// Time-division 1-to-4 demultiplexer: routes one shared word per valid cycle to
// one of four registered channels, by round-robin slot (frame mode) or by select (direct mode).
module tdm_demux4 #(
    parameter int WIDTH = 1
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    input  logic [WIDTH-1:0]     i_din,
    input  logic                 i_din_valid,
    input  logic                 i_sync,
    input  logic                 i_mode,
    input  logic [1:0]           i_sel,
    output logic [WIDTH-1:0]     o_ch0,
    output logic [WIDTH-1:0]     o_ch1,
    output logic [WIDTH-1:0]     o_ch2,
    output logic [WIDTH-1:0]     o_ch3,
    output logic [3:0]           o_ch_upd,
    output logic [1:0]           o_slot,
    output logic                 o_frame_valid,
    output logic [4*WIDTH-1:0]   o_frame,
    output logic                 o_sync_err
);

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] v;
        case (idx)
            2'd0:    v = 4'b0001;
            2'd1:    v = 4'b0010;
            2'd2:    v = 4'b0100;
            2'd3:    v = 4'b1000;
            default: v = 4'b0000;
        endcase
        return v;
    endfunction

    logic [WIDTH-1:0]   r_ch0, r_ch1, r_ch2, r_ch3;
    logic [1:0]         r_slot;
    logic [3:0]         r_fill;
    logic [3:0]         r_ch_upd;
    logic               r_frame_valid;
    logic               r_sync_err;
    logic [4*WIDTH-1:0] r_frame;

    logic               w_we;
    logic [1:0]         w_target;
    logic [1:0]         w_slot_nxt;
    logic [3:0]         w_fill_nxt;
    logic [3:0]         w_fill_acc;
    logic               w_fv;
    logic               w_serr;

    // Target selection, slot/fill advance and frame/sync-error detection.
    always_comb begin
        w_we       = 1'b0;
        w_target   = r_slot;
        w_slot_nxt = r_slot;
        w_fill_nxt = r_fill;
        w_fill_acc = r_fill;
        w_fv       = 1'b0;
        w_serr     = 1'b0;
        if (i_mode) begin
            // Direct mode keeps the frame machinery parked at slot 0, even when idle.
            w_slot_nxt = 2'd0;
            w_fill_nxt = 4'b0000;
            if (i_din_valid) begin
                w_we     = 1'b1;
                w_target = i_sel;
            end else begin
                w_we     = 1'b0;
            end
        end else if (i_din_valid) begin
            w_we = 1'b1;
            if (i_sync) begin
                w_target   = 2'd0;
                w_serr     = (r_fill != 4'b0000);
                w_fill_nxt = 4'b0001;
                w_slot_nxt = 2'd1;
            end else begin
                w_target   = r_slot;
                w_fill_acc = r_fill | onehot4(r_slot);
                if (r_slot == 2'd3) begin
                    w_fv       = (w_fill_acc[2:0] == 3'b111);
                    w_fill_nxt = 4'b0000;
                    w_slot_nxt = 2'd0;
                end else begin
                    w_fill_nxt = w_fill_acc;
                    w_slot_nxt = r_slot + 2'd1;
                end
            end
        end else begin
            w_we = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_ch0         <= {WIDTH{1'b0}};
            r_ch1         <= {WIDTH{1'b0}};
            r_ch2         <= {WIDTH{1'b0}};
            r_ch3         <= {WIDTH{1'b0}};
            r_slot        <= 2'd0;
            r_fill        <= 4'b0000;
            r_ch_upd      <= 4'b0000;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            r_frame       <= {(4*WIDTH){1'b0}};
        end else begin
            r_slot        <= w_slot_nxt;
            r_fill        <= w_fill_nxt;
            r_ch_upd      <= w_we ? onehot4(w_target) : 4'b0000;
            r_frame_valid <= w_fv;
            r_sync_err    <= w_serr;
            if (w_we) begin
                case (w_target)
                    2'd0:    r_ch0 <= i_din;
                    2'd1:    r_ch1 <= i_din;
                    2'd2:    r_ch2 <= i_din;
                    2'd3:    r_ch3 <= i_din;
                    default: r_ch0 <= r_ch0;
                endcase
            end
            if (w_fv) begin
                r_frame <= {i_din, r_ch2, r_ch1, r_ch0};
            end
        end
    end

    assign o_ch0         = r_ch0;
    assign o_ch1         = r_ch1;
    assign o_ch2         = r_ch2;
    assign o_ch3         = r_ch3;
    assign o_ch_upd      = r_ch_upd;
    assign o_slot        = r_slot;
    assign o_frame_valid = r_frame_valid;
    assign o_frame       = r_frame;
    assign o_sync_err    = r_sync_err;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4 (WIDTH=4); reference model collects the
// words of the current frame in a queue and releases a frame when it holds four.
module tb_tdm_demux4;
    localparam int W = 4;

    logic           clk;
    logic           resetn;
    logic [W-1:0]   din;
    logic           din_valid, sync, mode;
    logic [1:0]     sel;
    logic [W-1:0]   ch0, ch1, ch2, ch3;
    logic [3:0]     ch_upd;
    logic [1:0]     slot;
    logic           frame_valid, sync_err;
    logic [4*W-1:0] frame;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0]   m_ch [4];
    logic [W-1:0]   m_q [$];
    logic [4*W-1:0] m_frame;
    logic [3:0]     m_upd;
    logic           m_fv, m_serr;

    tdm_demux4 #(.WIDTH(W)) dut (
        .i_clk(clk), .i_resetn(resetn), .i_din(din), .i_din_valid(din_valid),
        .i_sync(sync), .i_mode(mode), .i_sel(sel),
        .o_ch0(ch0), .o_ch1(ch1), .o_ch2(ch2), .o_ch3(ch3), .o_ch_upd(ch_upd),
        .o_slot(slot), .o_frame_valid(frame_valid), .o_frame(frame), .o_sync_err(sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [39:0] obs_vec();
        return {ch3, ch2, ch1, ch0, ch_upd, slot, frame_valid, frame, sync_err};
    endfunction

    function automatic logic [39:0] exp_vec();
        logic [1:0] s;
        s = 2'(m_q.size());
        return {m_ch[3], m_ch[2], m_ch[1], m_ch[0], m_upd, s, m_fv, m_frame, m_serr};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_ch[i] = 4'h0;
        m_q.delete();
        m_frame = 16'h0;
        m_upd   = 4'b0000;
        m_fv    = 1'b0;
        m_serr  = 1'b0;
    endtask

    // Apply one cycle of stimulus, advance the model, sample 1 time unit after the edge.
    task automatic drive(input logic v, input logic s, input logic m,
                         input logic [1:0] sl, input logic [W-1:0] d);
        int idx;
        din = d; din_valid = v; sync = s; mode = m; sel = sl;
        m_upd = 4'b0000; m_fv = 1'b0; m_serr = 1'b0;
        if (!v) begin
            if (m) m_q.delete();
        end else if (m) begin
            m_ch[sl] = d;
            m_upd = 4'b0001 << sl;
            m_q.delete();
        end else if (s) begin
            m_serr = (m_q.size() != 0);
            m_q.delete();
            m_q.push_back(d);
            m_ch[0] = d;
            m_upd = 4'b0001;
        end else begin
            idx = m_q.size();
            m_ch[idx] = d;
            m_upd = 4'b0001 << idx;
            m_q.push_back(d);
            if (m_q.size() == 4) begin
                m_fv = 1'b1;
                m_frame = {m_q[3], m_q[2], m_q[1], m_q[0]};
                m_q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        din_valid = 1'b0; sync = 1'b0; mode = 1'b0; sel = 2'd0; din = 4'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (obs_vec() !== 40'h0) begin
            failures++;
            $display("FAIL reset_init: got %h exp %h", obs_vec(), 40'h0);
        end
        drive(1'b1, 1'b1, 1'b0, 2'd0, 4'hA);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 4'hB);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_prefill: got %h exp %h", obs_vec(), exp_vec());
        end
        #2 resetn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs_vec() !== 40'h0) begin
            failures++;
            $display("FAIL reset_async: got %h exp %h", obs_vec(), 40'h0);
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
        resetn = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
        checks++;
        if (slot !== 2'd0 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_release: got %h exp %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_frame();
        logic [W-1:0] words [4];
        words = '{4'hA, 4'hB, 4'hC, 4'hD};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 0), 1'b0, 2'd0, words[i]);
            checks++;
            if (obs_vec() !== exp_vec() || ch_upd !== (4'b0001 << i)) begin
                failures++;
                $display("FAIL frame_word%0d: got %h exp %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (frame_valid !== 1'b1 || frame !== 16'hDCBA || slot !== 2'd0) begin
            failures++;
            $display("FAIL frame_done: got fv=%b frame=%h slot=%0d exp fv=1 frame=dcba slot=0",
                     frame_valid, frame, slot);
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
        checks++;
        if (frame_valid !== 1'b0 || frame !== 16'hDCBA) begin
            failures++;
            $display("FAIL frame_hold: got fv=%b frame=%h exp fv=0 frame=dcba", frame_valid, frame);
        end
    endtask

    task automatic test_gapped();
        int fv_count = 0;
        logic [W-1:0] words [4];
        words = '{4'h1, 4'hE, 4'h5, 4'h9};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 0), 1'b0, 2'd0, words[i]);
            if (frame_valid === 1'b1) fv_count++;
            for (int g = 0; g < 2 && i < 3; g++) begin
                drive(1'b0, 1'b1, 1'b0, 2'd0, 4'hF);
                if (frame_valid === 1'b1) fv_count++;
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL gapped_hold%0d: got %h exp %h", i, obs_vec(), exp_vec());
                end
            end
        end
        checks++;
        if (fv_count != 1 || frame !== 16'h95E1) begin
            failures++;
            $display("FAIL gapped_frame: got count=%0d frame=%h exp count=1 frame=95e1", fv_count, frame);
        end
    endtask

    task automatic test_mid_sync();
        drive(1'b1, 1'b1, 1'b0, 2'd0, 4'h1);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 4'h2);
        drive(1'b1, 1'b1, 1'b0, 2'd0, 4'h7);
        checks++;
        if (sync_err !== 1'b1 || ch0 !== 4'h7 || slot !== 2'd1 || frame_valid !== 1'b0
            || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL mid_sync: got %h exp %h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 2'd0, 4'(i + 3));
            checks++;
            if (obs_vec() !== exp_vec() || frame_valid !== (i == 2)) begin
                failures++;
                $display("FAIL mid_sync_fill%0d: got %h exp %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (frame !== 16'h5437) begin
            failures++;
            $display("FAIL mid_sync_frame: got %h exp 5437", frame);
        end
    endtask

    task automatic test_direct();
        drive(1'b1, 1'b1, 1'b1, 2'd2, 4'h5);
        checks++;
        if (ch2 !== 4'h5 || ch_upd !== 4'b0100 || slot !== 2'd0 || frame_valid !== 1'b0
            || sync_err !== 1'b0 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL direct_write: got %h exp %h", obs_vec(), exp_vec());
        end
        for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, 1'b0, 2'd3, 4'(i));
        checks++;
        if (frame_valid !== 1'b1 || frame !== 16'h4321 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL direct_then_frame: got fv=%b frame=%h exp fv=1 frame=4321", frame_valid, frame);
        end
    endtask

    task automatic test_unaligned();
        logic [W-1:0] words [4];
        words = '{4'h9, 4'h8, 4'h7, 4'h6};
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 2'd0, words[i]);
        checks++;
        if (frame_valid !== 1'b1 || frame !== 16'h6789 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL unaligned_frame: got fv=%b frame=%h exp fv=1 frame=6789", frame_valid, frame);
        end
        drive(1'b1, 1'b0, 1'b0, 2'd0, 4'h3);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 4'h4);
        drive(1'b0, 1'b0, 1'b1, 2'd0, 4'h0);
        checks++;
        if (slot !== 2'd0 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL toggle_idle_clear: got %h exp %h", obs_vec(), exp_vec());
        end
        drive(1'b1, 1'b0, 1'b1, 2'd3, 4'hC);
        checks++;
        if (ch3 !== 4'hC || frame_valid !== 1'b0 || frame !== 16'h6789 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL ch3_alone: got %h exp %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        int fv_count = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, (i % 4 == 0), 1'b0, 2'd0, 4'($urandom_range(0, 15)));
            if (frame_valid === 1'b1) fv_count++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL b2b_cycle%0d: got %h exp %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (fv_count != 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d exp 3", fv_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_cycle%0d: got %h exp %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_frame();
        test_gapped();
        test_mid_sync();
        test_direct();
        test_unaligned();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
